div_job_arbiter: RTL and testbench

- Sequences the shared 4-bit integer divider datapath (CU_DP) and shares it between two requesters.
- Grants one requester at a time with round-robin fairness and latches its operands.
- Launches the divider with a one-cycle go pulse and captures quotient, remainder and error on the rising edge of done.
- Returns results through a per-requester response pulse. A watchdog recovers a hung divider by pulsing its reset.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_job_arbiter_if.sv | 43 ++++
 rtl/rr_arb2.sv | 23 ++
 rtl/div_job_arbiter.sv | 142 ++++++++++++++
 tb/tb_div_job_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the divider job arbiter: FSM encoding and
// default datapath/watchdog sizing.
package div_pkg;

    localparam int DIV_W       = 4;
    localparam int DIV_TIMEOUT = 64;
    localparam int DIV_TW      = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } div_state_e;

    // Requester ID of the peer in a two-way arbitration.
    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/div_job_arbiter_if.sv
// Bundle of requester, response and CU_DP signals around div_job_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface div_job_arbiter_if import div_pkg::*; #(parameter int W = DIV_W);

    logic         req0;
    logic [W-1:0] x0;
    logic [W-1:0] y0;
    logic         req1;
    logic [W-1:0] x1;
    logic [W-1:0] y1;

    logic         rsp_valid0;
    logic         rsp_valid1;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    logic         rsp_err;
    logic         rsp_timeout;
    logic         busy;

    logic         div_go;
    logic         div_rst;
    logic [W-1:0] div_x;
    logic [W-1:0] div_y;
    logic         div_done;
    logic         div_err;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;

    modport slave (
        input  req0, x0, y0, req1, x1, y1,
        input  div_done, div_err, div_q, div_r,
        output rsp_valid0, rsp_valid1, rsp_q, rsp_r, rsp_err, rsp_timeout, busy,
        output div_go, div_rst, div_x, div_y
    );

    modport master (
        output req0, x0, y0, req1, x1, y1,
        output div_done, div_err, div_q, div_r,
        input  rsp_valid0, rsp_valid1, rsp_q, rsp_r, rsp_err, rsp_timeout, busy,
        input  div_go, div_rst, div_x, div_y
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester wins outright,
// a tie goes to the requester that was not served last.
module rr_arb2 import div_pkg::*; (
    input  logic req0,
    input  logic req1,
    input  logic last_id,
    output logic gnt_valid,
    output logic gnt_id
);

    // Pick the winner from the request pair and the last-served ID.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = 1'b0;
        case ({req1, req0})
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = other_id(last_id);
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/div_job_arbiter.sv
// Shares one CU_DP divider between two requesters: grants round-robin, issues a
// go pulse, waits for a done rising edge or watchdog expiry, and returns results.
module div_job_arbiter import div_pkg::*; #(
    parameter int W              = DIV_W,
    parameter int TIMEOUT_CYCLES = DIV_TIMEOUT,
    parameter int TW             = DIV_TW
) (
    input  logic              clk,
    input  logic              rst,
    div_job_arbiter_if.slave  bus
);

    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

    div_state_e    state_r;
    logic          cur_id_r;
    logic          last_id_r;
    logic          done_q_r;
    logic [TW-1:0] wdog_r;
    logic [W-1:0]  x_r;
    logic [W-1:0]  y_r;
    logic          go_r;
    logic          drst_r;
    logic [W-1:0]  q_r;
    logic [W-1:0]  r_r;
    logic          err_r;
    logic          timeout_r;
    logic          valid0_r;
    logic          valid1_r;
    logic          busy_r;

    logic          gnt_valid_s;
    logic          gnt_id_s;

    rr_arb2 u_arb (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .last_id   (last_id_r),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // Job sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cur_id_r  <= 1'b0;
            last_id_r <= 1'b1;
            done_q_r  <= 1'b0;
            wdog_r    <= '0;
            x_r       <= '0;
            y_r       <= '0;
            go_r      <= 1'b0;
            drst_r    <= 1'b0;
            q_r       <= '0;
            r_r       <= '0;
            err_r     <= 1'b0;
            timeout_r <= 1'b0;
            valid0_r  <= 1'b0;
            valid1_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_q_r <= bus.div_done;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        cur_id_r <= gnt_id_s;
                        x_r      <= gnt_id_s ? bus.x1 : bus.x0;
                        y_r      <= gnt_id_s ? bus.y1 : bus.y0;
                        go_r     <= 1'b1;
                        busy_r   <= 1'b1;
                        done_q_r <= 1'b0;
                        state_r  <= ST_ISSUE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    go_r    <= 1'b0;
                    wdog_r  <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Only a fresh rising edge counts; a done held over from
                    // the previous job is already reflected in done_q_r.
                    if (bus.div_done && !done_q_r) begin
                        q_r       <= bus.div_q;
                        r_r       <= bus.div_r;
                        err_r     <= bus.div_err;
                        timeout_r <= 1'b0;
                        valid0_r  <= ~cur_id_r;
                        valid1_r  <= cur_id_r;
                        state_r   <= ST_RESP;
                    end else if (wdog_r == WD_LAST) begin
                        q_r       <= '0;
                        r_r       <= '0;
                        err_r     <= 1'b1;
                        timeout_r <= 1'b1;
                        drst_r    <= 1'b1;
                        state_r   <= ST_FLUSH;
                    end else begin
                        wdog_r    <= wdog_r + TW'(1);
                    end
                end
                ST_FLUSH: begin
                    drst_r   <= 1'b0;
                    valid0_r <= ~cur_id_r;
                    valid1_r <= cur_id_r;
                    state_r  <= ST_RESP;
                end
                ST_RESP: begin
                    valid0_r  <= 1'b0;
                    valid1_r  <= 1'b0;
                    last_id_r <= cur_id_r;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    go_r     <= 1'b0;
                    drst_r   <= 1'b0;
                    valid0_r <= 1'b0;
                    valid1_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid0  = valid0_r;
    assign bus.rsp_valid1  = valid1_r;
    assign bus.rsp_q       = q_r;
    assign bus.rsp_r       = r_r;
    assign bus.rsp_err     = err_r;
    assign bus.rsp_timeout = timeout_r;
    assign bus.busy        = busy_r;
    assign bus.div_go      = go_r;
    assign bus.div_rst     = drst_r;
    assign bus.div_x       = x_r;
    assign bus.div_y       = y_r;

endmodule

// File: tb/tb_div_job_arbiter.sv
// Directed bench for div_job_arbiter with a behavioural CU_DP model that can
// answer normally, hold a stale done, or hang.
module tb_div_job_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_job_arbiter_if #(.W(4)) bus ();

    div_job_arbiter #(.W(4), .TIMEOUT_CYCLES(64), .TW(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Divider model: 0 = normal, 1 = stale done held 3 cycles past go, 2 = hang.
    int mode = 0;
    int lat  = 10;
    int cnt  = 0;
    int drop = 0;
    bit pending = 1'b0;
    logic [3:0] mx, my;

    initial begin
        bus.div_done = 1'b0; bus.div_err = 1'b0; bus.div_q = 4'd0; bus.div_r = 4'd0;
        forever begin
            @(posedge clk); #1;
            if (rst || bus.div_rst) begin
                bus.div_done = 1'b0; bus.div_err = 1'b0; bus.div_q = 4'd0; bus.div_r = 4'd0;
                pending = 1'b0; drop = 0;
            end else begin
                if (drop > 0) begin
                    drop--;
                    if (drop == 0) bus.div_done = 1'b0;
                end
                if (bus.div_go) begin
                    pending = 1'b1; cnt = lat; mx = bus.div_x; my = bus.div_y;
                    if (mode == 1) drop = 3;
                    else bus.div_done = 1'b0;
                end else if (pending && mode != 2) begin
                    if (cnt > 0) cnt--;
                    else begin
                        bus.div_done = 1'b1;
                        bus.div_err  = (my == 4'd0);
                        bus.div_q    = (my == 4'd0) ? 4'd0 : mx / my;
                        bus.div_r    = (my == 4'd0) ? 4'd0 : mx % my;
                        pending = 1'b0;
                    end
                end
            end
        end
    end

    // Event monitor sampled on the falling edge.
    int cyc = 0, go_cnt = 0, go_cyc = 0, drst_cnt = 0, rsp_cnt = 0, rsp_lat = 0, excl_bad = 0;
    logic [3:0] go_x, go_y;
    always @(negedge clk) begin
        cyc++;
        if (bus.div_go) begin go_cnt++; go_cyc = cyc; go_x = bus.div_x; go_y = bus.div_y; end
        if (bus.div_rst) drst_cnt++;
        if (bus.rsp_valid0 || bus.rsp_valid1) begin rsp_cnt++; rsp_lat = cyc - go_cyc; end
        if ((bus.rsp_valid0 && bus.rsp_valid1) || (bus.div_go && bus.div_rst)) excl_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic       got_id;
    logic [3:0] got_q, got_r;
    logic       got_err, got_to;

    task automatic wait_rsp(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (bus.rsp_valid0 || bus.rsp_valid1) begin
                ok = 1'b1; got_id = bus.rsp_valid1;
                got_q = bus.rsp_q; got_r = bus.rsp_r; got_err = bus.rsp_err; got_to = bus.rsp_timeout;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: no rsp_valid within 200 cycles", name);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [3:0] x, input logic [3:0] y);
        if (id) begin bus.req1 = v; bus.x1 = x; bus.y1 = y; end
        else    begin bus.req0 = v; bus.x0 = x; bus.y0 = y; end
    endtask

    task automatic do_job(input string name, input logic id, input logic [3:0] x, input logic [3:0] y,
                          input logic [3:0] eq, input logic [3:0] er, input logic ee, input logic et);
        int g0, r0;
        bit ok;
        g0 = go_cnt; r0 = rsp_cnt;
        set_req(id, 1'b1, x, y);
        wait_rsp(name, ok);
        set_req(id, 1'b0, x, y);
        if (ok) begin
            check({name, "_id"},  32'(got_id),  32'(id));
            check({name, "_q"},   32'(got_q),   32'(eq));
            check({name, "_r"},   32'(got_r),   32'(er));
            check({name, "_err"}, 32'(got_err), 32'(ee));
            check({name, "_to"},  32'(got_to),  32'(et));
        end
        @(negedge clk);
        check({name, "_gos"},  32'(go_cnt - g0),  32'd1);
        check({name, "_rsps"}, 32'(rsp_cnt - r0), 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_q, bus.rsp_r, bus.rsp_err,
                    bus.rsp_timeout, bus.busy, bus.div_go, bus.div_rst, bus.div_x, bus.div_y});
    endfunction

    typedef struct {
        logic       id;
        logic [3:0] x, y, q, r;
        logic       err;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] ox0[3], oy0[3], ox1[3], oy1[3];

    initial begin
        bit ok;
        int k0, k1, r0, g0, d0;
        logic [3:0] ex, ey;
        vecs[0] = '{1'b0, 4'd13, 4'd4,  4'd3,  4'd1, 1'b0};
        vecs[1] = '{1'b1, 4'd7,  4'd0,  4'd0,  4'd0, 1'b1};
        vecs[2] = '{1'b0, 4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[3] = '{1'b1, 4'd5,  4'd7,  4'd0,  4'd5, 1'b0};
        vecs[4] = '{1'b0, 4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[5] = '{1'b1, 4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        ox0 = '{4'd13, 4'd14, 4'd9}; oy0 = '{4'd4, 4'd5, 4'd9};
        ox1 = '{4'd11, 4'd8,  4'd6}; oy1 = '{4'd2, 4'd3, 4'd0};
        bus.req0 = 1'b0; bus.x0 = 4'd0; bus.y0 = 4'd0;
        bus.req1 = 1'b0; bus.x1 = 4'd0; bus.y1 = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outs", all_outs(), 32'd0);

        // Single jobs from the table
        for (int i = 0; i < 6; i++)
            do_job($sformatf("vec%0d", i), vecs[i].id, vecs[i].x, vecs[i].y,
                   vecs[i].q, vecs[i].r, vecs[i].err, 1'b0);

        // Stale done: job 1 leaves done high; job 2 must wait for its own edge
        mode = 0;
        do_job("stale_a", 1'b0, 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b0);
        mode = 1;
        do_job("stale_b", 1'b1, 4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 1'b0);
        mode = 0;

        // Hang: watchdog fires, one div_rst, then a normal job
        mode = 2; d0 = drst_cnt;
        do_job("hang", 1'b0, 4'd9, 4'd2, 4'd0, 4'd0, 1'b1, 1'b1);
        check("hang_drst", 32'(drst_cnt - d0), 32'd1);
        check("hang_lat",  32'(rsp_lat), 32'd66);
        mode = 0;
        do_job("post_hang", 1'b1, 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0);

        // Contention from reset: order 0,1,0,1,0,1
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k0 = 0; k1 = 0; g0 = go_cnt;
        set_req(1'b0, 1'b1, ox0[0], oy0[0]);
        set_req(1'b1, 1'b1, ox1[0], oy1[0]);
        for (int i = 0; i < 6; i++) begin
            wait_rsp($sformatf("cont%0d", i), ok);
            if (ok) begin
                ex = got_id ? ox1[k1] : ox0[k0];
                ey = got_id ? oy1[k1] : oy0[k0];
                check($sformatf("cont%0d_id", i),  32'(got_id), 32'(i % 2));
                check($sformatf("cont%0d_q", i),   32'(got_q),  (ey == 4'd0) ? 32'd0 : 32'(ex / ey));
                check($sformatf("cont%0d_r", i),   32'(got_r),  (ey == 4'd0) ? 32'd0 : 32'(ex % ey));
                check($sformatf("cont%0d_err", i), 32'(got_err), 32'(ey == 4'd0));
                check($sformatf("cont%0d_ops", i), 32'({go_x, go_y}), 32'({ex, ey}));
                if (got_id) begin k1++; if (k1 < 3) set_req(1'b1, 1'b1, ox1[k1], oy1[k1]); end
                else        begin k0++; if (k0 < 3) set_req(1'b0, 1'b1, ox0[k0], oy0[k0]); end
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("cont_gos", 32'(go_cnt - g0), 32'd6);

        // Reset mid-WAIT, request held and re-served
        set_req(1'b1, 1'b1, 4'd14, 4'd3);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.div_go;
        end
        check("rstmid_go_seen", 32'(ok), 32'd1);
        r0 = rsp_cnt;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rstmid_outs", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        wait_rsp("rstmid", ok);
        set_req(1'b1, 1'b0, 4'd14, 4'd3);
        if (ok) begin
            check("rstmid_id", 32'(got_id), 32'd1);
            check("rstmid_q",  32'(got_q),  32'd4);
            check("rstmid_r",  32'(got_r),  32'd2);
            check("rstmid_to", 32'(got_to), 32'd0);
        end
        repeat (3) @(negedge clk);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("exclusive", 32'(excl_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
